// File: rtl/bundle_dispatch_if.sv
// Bundle memory read port: request/address from the dispatcher, data/ready from memory.
// Slot i of memData occupies bits [32i+31:32i].
interface bundle_dispatch_if #(
    parameter int unsigned NUM_SLOTS = 4
);
    logic                       memReadEnable;
    logic [63:0]                memAddress;
    logic [32*NUM_SLOTS-1:0]    memData;
    logic                       memReady;

    modport master (
        output memReadEnable,
        output memAddress,
        input  memData,
        input  memReady
    );

    modport slave (
        input  memReadEnable,
        input  memAddress,
        output memData,
        output memReady
    );
endinterface

// File: rtl/bundle_dispatch.sv
// Bundle fetch/issue sequencer: FETCH -> FETCH_WAIT -> ISSUE -> SETTLE(2) -> WAIT_FU -> FETCH.
// Optional macro DISPATCH_PERF_COUNTERS_EN adds bundleCount and stallCycles outputs.
module bundle_dispatch #(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter logic [63:0] RESET_ADDR = 64'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      do_stall,
    bundle_dispatch_if.master         mem,
    output logic [32*NUM_SLOTS-1:0]   instruction,
    output logic [63:0]               bundleAddr,
    output logic [NUM_SLOTS-1:0]      instructionReady,
    input  logic [NUM_SLOTS-1:0]      fuWorking,
    input  logic                      redirectValid,
    input  logic [63:0]               redirectAddr,
    output logic                      busy
`ifdef DISPATCH_PERF_COUNTERS_EN
    ,
    output logic [63:0]               bundleCount,
    output logic [63:0]               stallCycles
`endif
);

    localparam logic [2:0] StFetch     = 3'd0;
    localparam logic [2:0] StFetchWait = 3'd1;
    localparam logic [2:0] StIssue     = 3'd2;
    localparam logic [2:0] StSettle    = 3'd3;
    localparam logic [2:0] StWaitFu    = 3'd4;

    localparam int unsigned BundleW = 32 * NUM_SLOTS;
    localparam logic [63:0] PcStep  = 64'(4 * NUM_SLOTS);

    logic [2:0]           state_q, state_d;
    logic                 settle_q, settle_d;
    logic [63:0]          pc_q, pc_d;
    logic                 redir_pend_q, redir_pend_d;
    logic [63:0]          redir_addr_q, redir_addr_d;
    logic                 mem_re_q, mem_re_d;
    logic [63:0]          mem_addr_q, mem_addr_d;
    logic [BundleW-1:0]   instr_q, instr_d;
    logic [63:0]          baddr_q, baddr_d;
    logic [NUM_SLOTS-1:0] irdy_q, irdy_d;
    logic                 busy_q, busy_d;

    logic                 latch_en;
    logic                 retire;
    logic [63:0]          next_pc;

    assign latch_en = (state_q == StIssue) || (state_q == StSettle) || (state_q == StWaitFu);

    // A redirect presented in the retirement cycle itself overrides anything latched earlier.
    always_comb begin
        if (redirectValid) begin
            next_pc = redirectAddr;
        end else if (redir_pend_q) begin
            next_pc = redir_addr_q;
        end else begin
            next_pc = pc_q + PcStep;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        redir_addr_d = redir_addr_q;
        mem_re_d     = mem_re_q;
        mem_addr_d   = mem_addr_q;
        instr_d      = instr_q;
        baddr_d      = baddr_q;
        irdy_d       = irdy_q;
        retire       = 1'b0;

        if (latch_en && redirectValid) begin
            redir_pend_d = 1'b1;
            redir_addr_d = redirectAddr;
        end

        unique case (state_q)
            StFetch: begin
                if (!do_stall) begin
                    mem_re_d   = 1'b1;
                    mem_addr_d = pc_q;
                    state_d    = StFetchWait;
                end
            end
            StFetchWait: begin
                // Stall is deliberately not consulted: an accepted bundle must be captured.
                if (mem.memReady) begin
                    instr_d  = mem.memData;
                    baddr_d  = pc_q;
                    mem_re_d = 1'b0;
                    irdy_d   = '1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                irdy_d   = '0;
                settle_d = 1'b0;
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_q) begin
                    state_d = StWaitFu;
                end else begin
                    settle_d = 1'b1;
                end
            end
            StWaitFu: begin
                if ((fuWorking == '0) && !do_stall) begin
                    retire       = 1'b1;
                    pc_d         = next_pc;
                    redir_pend_d = 1'b0;
                    state_d      = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        busy_d = (state_d != StFetch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFetch;
            settle_q     <= 1'b0;
            pc_q         <= RESET_ADDR;
            redir_pend_q <= 1'b0;
            redir_addr_q <= '0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            instr_q      <= '0;
            baddr_q      <= '0;
            irdy_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            pc_q         <= pc_d;
            redir_pend_q <= redir_pend_d;
            redir_addr_q <= redir_addr_d;
            mem_re_q     <= mem_re_d;
            mem_addr_q   <= mem_addr_d;
            instr_q      <= instr_d;
            baddr_q      <= baddr_d;
            irdy_q       <= irdy_d;
            busy_q       <= busy_d;
        end
    end

    assign mem.memReadEnable = mem_re_q;
    assign mem.memAddress    = mem_addr_q;
    assign instruction       = instr_q;
    assign bundleAddr        = baddr_q;
    assign instructionReady  = irdy_q;
    assign busy              = busy_q;

`ifdef DISPATCH_PERF_COUNTERS_EN
    logic [63:0] bundle_cnt_q;
    logic [63:0] stall_cnt_q;
    logic        stall_cnt_en;

    // Only stalls that actually hold the pipeline (fetch or retirement) are counted.
    assign stall_cnt_en = do_stall && ((state_q == StFetch) || (state_q == StWaitFu));

    always_ff @(posedge clk) begin
        if (rst) begin
            bundle_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (retire) begin
                bundle_cnt_q <= bundle_cnt_q + 64'd1;
            end
            if (stall_cnt_en) begin
                stall_cnt_q <= stall_cnt_q + 64'd1;
            end
        end
    end

    assign bundleCount = bundle_cnt_q;
    assign stallCycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bundle_dispatch.sv
// Scoreboard bench for bundle_dispatch: stimulus pushes expected fetches/issues, a monitor
// pops and compares whenever the DUT raises memReadEnable or instructionReady.
module tb_bundle_dispatch;

    localparam logic [127:0] D0 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [63:0]  WrapReset = 64'hFFFF_FFFF_FFFF_FFF0;

    typedef struct packed {
        logic [127:0] instr;
        logic [63:0]  addr;
    } iss_t;

    logic         clk, rst, do_stall, redirectValid;
    logic [63:0]  redirectAddr;
    logic [3:0]   fuWorking;
    logic [127:0] instruction;
    logic [63:0]  bundleAddr;
    logic [3:0]   instructionReady;
    logic         busy;

    logic [127:0] w_instr;
    logic [63:0]  w_baddr;
    logic [3:0]   w_irdy;
    logic         w_busy;

`ifdef DISPATCH_PERF_COUNTERS_EN
    logic [63:0]  bundleCount, stallCycles, w_bcnt, w_scnt;
`endif

    int n_pass, n_total, cyc, mem_lat;
    logic mem_rdy_model, mem_force, w_rdy;
    logic [127:0] mem_data_v;

    logic [63:0] exp_addr[$];
    iss_t        exp_iss[$];
    logic [63:0] w_addrs[$];

    bundle_dispatch_if #(.NUM_SLOTS(4)) mem ();
    bundle_dispatch_if #(.NUM_SLOTS(4)) mem2 ();

    assign mem.memReady  = mem_rdy_model | mem_force;
    assign mem.memData   = mem_data_v;
    assign mem2.memReady = w_rdy;
    assign mem2.memData  = '0;

    bundle_dispatch #(.NUM_SLOTS(4), .RESET_ADDR(64'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .do_stall         (do_stall),
        .mem              (mem),
        .instruction      (instruction),
        .bundleAddr       (bundleAddr),
        .instructionReady (instructionReady),
        .fuWorking        (fuWorking),
        .redirectValid    (redirectValid),
        .redirectAddr     (redirectAddr),
        .busy             (busy)
`ifdef DISPATCH_PERF_COUNTERS_EN
        ,
        .bundleCount      (bundleCount),
        .stallCycles      (stallCycles)
`endif
    );

    bundle_dispatch #(.NUM_SLOTS(4), .RESET_ADDR(WrapReset)) dut_wrap (
        .clk              (clk),
        .rst              (rst),
        .do_stall         (do_stall),
        .mem              (mem2),
        .instruction      (w_instr),
        .bundleAddr       (w_baddr),
        .instructionReady (w_irdy),
        .fuWorking        (4'b0000),
        .redirectValid    (1'b0),
        .redirectAddr     (64'h0),
        .busy             (w_busy)
`ifdef DISPATCH_PERF_COUNTERS_EN
        ,
        .bundleCount      (w_bcnt),
        .stallCycles      (w_scnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic logic [127:0] bd(input logic [63:0] a);
        logic [127:0] r;
        r = '0;
        if (a == 64'h0) return D0;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = a[31:0] + 32'h01010101 * 32'(i + 1);
        return r;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic fail_evt(input string nm, input logic [127:0] act);
        n_total++;
        $display("FAIL %s: got %0h, expected no such event", nm, act);
    endtask

    task automatic wait_issue(output int c);
        c = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (instructionReady != 4'b0) begin
                c = cyc;
                return;
            end
        end
        fail_evt("issue_timeout", 128'(cyc));
    endtask

    task automatic wait_req(output int c);
        c = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (mem.memReadEnable) begin
                c = cyc;
                return;
            end
        end
        fail_evt("fetch_timeout", 128'(cyc));
    endtask

    task automatic push_bundle(input logic [63:0] a, input logic [127:0] d);
        iss_t e;
        e.instr = d;
        e.addr  = a;
        exp_addr.push_back(a);
        exp_iss.push_back(e);
    endtask

    // Memory model: answers a held request after mem_lat extra cycles.
    initial begin
        int wcnt;
        wcnt = 0;
        mem_rdy_model = 1'b0;
        mem_data_v = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rdy_model = 1'b0;
            if (mem.memReadEnable) begin
                if (wcnt >= mem_lat) begin
                    mem_rdy_model = 1'b1;
                    mem_data_v = bd(mem.memAddress);
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        w_rdy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            w_rdy = mem2.memReadEnable;
        end
    end

    // Monitor: pops the scoreboard on every new fetch request and every issue strobe.
    initial begin
        logic prev_re, prev_re2;
        logic [3:0] prev_rdy;
        iss_t e;
        prev_re = 1'b0;
        prev_re2 = 1'b0;
        prev_rdy = 4'b0;
        forever begin
            @(negedge clk);
            if (mem.memReadEnable && !prev_re) begin
                if (exp_addr.size() == 0) fail_evt("unexpected_fetch", 128'(mem.memAddress));
                else check("fetch_addr", 128'(mem.memAddress), 128'(exp_addr.pop_front()));
            end
            if (instructionReady != 4'b0) begin
                check("iready_all", 128'(instructionReady), 128'hF);
                if (prev_rdy != 4'b0) fail_evt("iready_held", 128'(instructionReady));
                if (exp_iss.size() == 0) begin
                    fail_evt("unexpected_issue", 128'(bundleAddr));
                end else begin
                    e = exp_iss.pop_front();
                    check("issue_instr", instruction, e.instr);
                    check("issue_baddr", 128'(bundleAddr), 128'(e.addr));
                end
            end
            if (mem2.memReadEnable && !prev_re2 && w_addrs.size() < 2) begin
                w_addrs.push_back(mem2.memAddress);
            end
            prev_re  = mem.memReadEnable;
            prev_re2 = mem2.memReadEnable;
            prev_rdy = instructionReady;
        end
    end

    initial begin
        int i1, i2, i3, i4, i5, i6, i7, i9, r, r6, r8;
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        do_stall = 1'b0;
        redirectValid = 1'b0;
        redirectAddr = '0;
        fuWorking = 4'b0;
        mem_lat = 1;
        mem_force = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_mem_re", 128'(mem.memReadEnable), 128'd0);
        check("rst_mem_addr", 128'(mem.memAddress), 128'd0);
        check("rst_instr", instruction, 128'd0);
        check("rst_baddr", 128'(bundleAddr), 128'd0);
        check("rst_iready", 128'(instructionReady), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
`ifdef DISPATCH_PERF_COUNTERS_EN
        check("rst_bundle_count", 128'(bundleCount), 128'd0);
        check("rst_stall_cycles", 128'(stallCycles), 128'd0);
`endif
        push_bundle(64'h0, 128'h44444444_33333333_22222222_11111111);
        rst = 1'b0;

        // Bundle at 0 with one-cycle memory; then idle units give a 5-cycle issue-to-fetch gap.
        wait_issue(i1);
        check("busy_in_issue", 128'(busy), 128'd1);
        mem_lat = 0;
        push_bundle(64'h10, bd(64'h10));
        wait_req(r);
        check("idle_period", 128'(r - i1), 128'd5);

        // Unit 2 busy for 5 WAIT_FU cycles delays the next fetch by 5.
        wait_issue(i2);
        fuWorking = 4'b0100;
        push_bundle(64'h20, bd(64'h20));
        repeat (8) @(negedge clk);
        fuWorking = 4'b0000;
        wait_req(r);
        check("fu_hold_period", 128'(r - i2), 128'd10);

        // Redirect pulsed in SETTLE.
        wait_issue(i3);
        push_bundle(64'h2000, bd(64'h2000));
        @(negedge clk);
        redirectValid = 1'b1;
        redirectAddr = 64'h2000;
        @(negedge clk);
        redirectValid = 1'b0;
        redirectAddr = 64'hDEAD_0000;
        wait_req(r);
        check("redirect_period", 128'(r - i3), 128'd5);

        wait_issue(i4);
        push_bundle(64'h2010, bd(64'h2010));
        wait_req(r);

        // Redirect only in the retirement cycle.
        wait_issue(i5);
        push_bundle(64'h3000, bd(64'h3000));
        repeat (3) @(negedge clk);
        redirectValid = 1'b1;
        redirectAddr = 64'h3000;
        @(negedge clk);
        redirectValid = 1'b0;
        wait_req(r);
        check("retire_redirect_period", 128'(r - i5), 128'd5);

        // Last redirect wins, and it survives a 3-cycle stall in WAIT_FU.
        wait_issue(i6);
        push_bundle(64'h5000, bd(64'h5000));
        redirectValid = 1'b1;
        redirectAddr = 64'h4000;
        @(negedge clk);
        redirectAddr = 64'h5000;
        @(negedge clk);
        redirectValid = 1'b0;
        redirectAddr = 64'h7777;
        @(negedge clk);
        do_stall = 1'b1;
        repeat (3) @(negedge clk);
        do_stall = 1'b0;
        wait_req(r6);
        check("stall_period", 128'(r6 - i6), 128'd8);
`ifdef DISPATCH_PERF_COUNTERS_EN
        check("bundle_count", 128'(bundleCount), 128'd6);
        check("stall_cycles", 128'(stallCycles), 128'd3);
`endif

        // Stall and redirect during FETCH_WAIT: capture proceeds, redirect ignored.
        do_stall = 1'b1;
        redirectValid = 1'b1;
        redirectAddr = 64'h9000;
        exp_addr.push_back(64'h5010);
        wait_issue(i7);
        do_stall = 1'b0;
        redirectValid = 1'b0;
        check("stall_no_block", 128'(i7 - r6), 128'd1);

        // Reset in FETCH_WAIT with memReady asserted; memReady also forced the cycle after.
        wait_req(r8);
        rst = 1'b1;
        mem_force = 1'b1;
        push_bundle(64'h0, D0);
        @(negedge clk);
        rst = 1'b0;
        check("rst2_mem_re", 128'(mem.memReadEnable), 128'd0);
        check("rst2_iready", 128'(instructionReady), 128'd0);
        check("rst2_busy", 128'(busy), 128'd0);
        check("rst2_instr", instruction, 128'd0);
`ifdef DISPATCH_PERF_COUNTERS_EN
        check("rst2_stall_cycles", 128'(stallCycles), 128'd0);
`endif
        @(negedge clk);
        mem_force = 1'b0;
        wait_issue(i9);
        check("post_reset_issue", 128'(i9 - r8), 128'd3);
        fuWorking = 4'hF;
        repeat (10) @(negedge clk);

        check("sb_addr_empty", 128'(exp_addr.size()), 128'd0);
        check("sb_iss_empty", 128'(exp_iss.size()), 128'd0);
        if (w_addrs.size() == 2) begin
            check("wrap_first", 128'(w_addrs[0]), 128'(WrapReset));
            check("wrap_second", 128'(w_addrs[1]), 128'd0);
        end else begin
            fail_evt("wrap_fetch_count", 128'(w_addrs.size()));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bundle_dispatch.md
BUNDLE_DISPATCH -- requirements
Module: bundle_dispatch

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of functional-unit slots per bundle (1..8).
REQ-002 SHALL have parameter RESET_ADDR, default 64'h0, first bundle address after reset.
REQ-003 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port do_stall  input  1  global stall; blocks new fetch and bundle retirement.
REQ-006 SHALL have port memReadEnable  output  1  bundle read request, held until memReady.
REQ-007 SHALL have port memAddress  output  64  bundle read address.
REQ-008 SHALL have port memData  input  32*NUM_SLOTS  bundle; slot i at bits [32i+31:32i].
REQ-009 SHALL have port memReady  input  1  memData valid this cycle.
REQ-010 SHALL have port instruction  output  32*NUM_SLOTS  per-slot instruction word, same packing as memData.
REQ-011 SHALL have port bundleAddr  output  64  address of the bundle currently issued.
REQ-012 SHALL have port instructionReady  output  NUM_SLOTS  per-slot one-cycle issue strobe.
REQ-013 SHALL have port fuWorking  input  NUM_SLOTS  per-slot functional-unit busy flag.
REQ-014 SHALL have port redirectValid  input  1  control-flow redirect request.
REQ-015 SHALL have port redirectAddr  input  64  redirect target bundle address.
REQ-016 SHALL have port busy  output  1  high in every state except FETCH.

Function
REQ-017 SHALL implement states FETCH, FETCH_WAIT, ISSUE, SETTLE, WAIT_FU; all outputs registered.
REQ-018 FETCH: if !do_stall, set memReadEnable=1, memAddress=pc, go FETCH_WAIT next cycle; if do_stall, remain.
REQ-019 FETCH_WAIT: hold memReadEnable=1 and memAddress; on memReady in cycle N, capture memData into instruction, pc into bundleAddr, drop memReadEnable, and assert instructionReady all-ones, all visible in cycle N+1 (state ISSUE).
REQ-020 FETCH_WAIT: do_stall SHALL NOT block capture; an accepted bundle is never dropped.
REQ-021 ISSUE: lasts exactly one cycle; instructionReady cleared at its end; go SETTLE.
REQ-022 SETTLE: exactly two cycles, fuWorking ignored (covers the unit's one-cycle busy-flag lag).
REQ-023 WAIT_FU: when fuWorking==0 and !do_stall, retire bundle: pc<=next_pc, go FETCH.
REQ-024 next_pc SHALL be the latched redirect target if a redirect is pending, else pc + 4*NUM_SLOTS, modulo 2^64 (wraps at all-ones).
REQ-025 redirectValid SHALL be latched (last value wins) in ISSUE, SETTLE and WAIT_FU, including while stalled, and cleared on retirement; ignored in FETCH and FETCH_WAIT.
REQ-026 Redirect asserted in the retirement cycle itself SHALL be honoured for that retirement.
REQ-027 Minimum bundle period with single-cycle memory and idle units: 6 cycles from FETCH to next FETCH.
REQ-028 instruction and bundleAddr SHALL remain stable from ISSUE until the next memReady capture.

Reset
REQ-029 rst high at a clock edge, in any state, SHALL force state FETCH, pc=RESET_ADDR, redirect pending cleared.
REQ-030 Reset values: memReadEnable=0, memAddress=0, instruction=0, bundleAddr=0, instructionReady=0, busy=0.
REQ-031 memReady arriving in the reset cycle or the cycle after SHALL be ignored; in-flight reads abandoned.
REQ-032 rst SHALL take priority over do_stall, redirectValid and memReady.

Configuration
REQ-033 Macro DISPATCH_PERF_COUNTERS_EN, when defined, SHALL add outputs bundleCount (64) and stallCycles (64).
REQ-034 With macro: bundleCount increments on every retirement; stallCycles increments each cycle do_stall is high in FETCH or WAIT_FU; both reset to 0 and wrap.
REQ-035 Without macro: these ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-036 Reset then memReady one cycle after request, memData slots 0..3 = 11111111,22222222,33333333,44444444, fuWorking=0 -> memAddress 0, instructionReady=4'b1111 one cycle, next memAddress 0x10.
REQ-037 fuWorking=4'b0100 held 5 cycles after SETTLE -> no new memReadEnable until cycle after fuWorking falls to 0.
REQ-038 redirectValid=1, redirectAddr=0x2000 pulsed during SETTLE -> next memAddress 0x2000, following one 0x2010.
REQ-039 RESET_ADDR=64'hFFFF_FFFF_FFFF_FFF0, NUM_SLOTS=4 -> second fetch at address 0x0.
REQ-040 rst asserted in FETCH_WAIT with memReady same cycle -> instructionReady never asserted, next memAddress = RESET_ADDR.
REQ-041 do_stall high 3 cycles in WAIT_FU with fuWorking=0 -> retirement delayed 3 cycles; with macro, stallCycles=3.
